fu_mul_seq: RTL and testbench

Sequencer and arbiter for the shared 32-bit function unit (FS/SH/A/B in, F/V/C/N/Z out). When idle it passes the pipeline's function-unit request straight through. On `start` it takes ownership of the function unit and computes an unsigned 32×32 multiply by iterative shift-and-add, issuing one function-unit operation per cycle. It returns the low 32 product bits plus an exact overflow flag, and holds `busy` so the pipeline stalls.

---
 rtl/fu_mul_seq_if.sv | 45 ++++
 rtl/fu_mul_seq.sv | 163 ++++++++++++++++
 tb/tb_fu_mul_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_mul_seq_if.sv
// Bundle of the multiplier request/response signals, the pipeline's
// function-unit request and the shared function-unit port.
//   start/op_a/op_b      : multiply request (master -> slave)
//   busy/done/result/ovf : multiply status and result (slave -> master)
//   pipe_FS/SH/A/B       : pipeline function-unit request (master -> slave)
//   fu_FS/SH/A/B         : function-unit drive (slave -> function unit)
//   fu_F/fu_C/fu_Z       : function-unit result and flags (function unit -> slave)
interface fu_mul_seq_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    logic [3:0]  pipe_FS;
    logic [4:0]  pipe_SH;
    logic [31:0] pipe_A;
    logic [31:0] pipe_B;

    logic [3:0]  fu_FS;
    logic [4:0]  fu_SH;
    logic [31:0] fu_A;
    logic [31:0] fu_B;
    logic [31:0] fu_F;
    logic        fu_C;
    logic        fu_Z;

    modport slave (
        input  start, op_a, op_b,
        input  pipe_FS, pipe_SH, pipe_A, pipe_B,
        input  fu_F, fu_C, fu_Z,
        output busy, done, result, ovf,
        output fu_FS, fu_SH, fu_A, fu_B
    );

    modport master (
        output start, op_a, op_b,
        output pipe_FS, pipe_SH, pipe_A, pipe_B,
        output fu_F, fu_C, fu_Z,
        input  busy, done, result, ovf,
        input  fu_FS, fu_SH, fu_A, fu_B
    );
endinterface

// File: rtl/fu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the shared 32-bit function unit.
// In IDLE the pipeline request passes straight through to the function unit;
// once a multiply starts, the sequencer issues one ADD/SHL/SHR per cycle until
// the multiplier is exhausted, then presents the low product word and an exact
// overflow flag.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fu_mul_seq_if.slave (request, status, pipeline and function-unit port)
module fu_mul_seq (
    input logic         clk,
    input logic         rst,
    fu_mul_seq_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FS_W   = 4;
    localparam int unsigned SH_W   = 5;

    localparam logic [FS_W-1:0] FS_ADD = 4'b0010;
    localparam logic [FS_W-1:0] FS_SHL = 4'b1110;
    localparam logic [FS_W-1:0] FS_SHR = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   p_q, p_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic                acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [FS_W-1:0]     fu_fs_c;
    logic [SH_W-1:0]     fu_sh_c;
    logic [DATA_W-1:0]   fu_a_c;
    logic [DATA_W-1:0]   fu_b_c;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, datapath update and function-unit port mux.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        fu_fs_c  = '0;
        fu_sh_c  = '0;
        fu_a_c   = '0;
        fu_b_c   = '0;

        case (state_q)
            S_IDLE: begin
                fu_fs_c = bus.pipe_FS;
                fu_sh_c = bus.pipe_SH;
                fu_a_c  = bus.pipe_A;
                fu_b_c  = bus.pipe_B;
                if (bus.start) begin
                    p_d   = '0;
                    m_d   = bus.op_a;
                    q_d   = bus.op_b;
                    acc_d = 1'b0;
                    if (bus.op_b == '0) begin
                        // Zero multiplier: product is known without using the unit.
                        state_d  = S_DONE;
                        result_d = '0;
                        ovf_d    = 1'b0;
                    end else if (bus.op_b[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHL;
                    end
                end
            end
            S_ADD: begin
                fu_fs_c = FS_ADD;
                fu_a_c  = p_q;
                fu_b_c  = m_q;
                p_d     = bus.fu_F;
                acc_d   = acc_q | bus.fu_C;
                state_d = S_SHL;
            end
            S_SHL: begin
                fu_fs_c = FS_SHL;
                fu_sh_c = SH_W'(1);
                fu_b_c  = m_q;
                m_d     = bus.fu_F;
                // A multiplicand bit shifted out still has multiplier bits left to meet it.
                acc_d   = acc_q | (m_q[DATA_W-1] & (|q_q[DATA_W-1:1]));
                state_d = S_SHR;
            end
            S_SHR: begin
                fu_fs_c = FS_SHR;
                fu_sh_c = SH_W'(1);
                fu_b_c  = q_q;
                q_d     = bus.fu_F;
                if (bus.fu_Z) begin
                    // P and the accumulator are final; publish on entry to DONE.
                    state_d  = S_DONE;
                    result_d = p_q;
                    ovf_d    = acc_q;
                end else if (bus.fu_F[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

    // The function-unit drive is combinational so the pipeline sees no extra latency in IDLE.
    assign bus.fu_FS  = fu_fs_c;
    assign bus.fu_SH  = fu_sh_c;
    assign bus.fu_A   = fu_a_c;
    assign bus.fu_B   = fu_b_c;
endmodule

// File: tb/tb_fu_mul_seq.sv
// Self-checking bench for fu_mul_seq: models the combinational function unit,
// predicts each multiply from plain 64-bit arithmetic and the operation
// sequence implied by the multiplier bits.
module tb_fu_mul_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fu_mul_seq_if bus ();

    fu_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function unit model.
    logic [32:0] fu_sum;
    always_comb begin
        fu_sum     = 33'd0;
        bus.fu_F   = 32'd0;
        bus.fu_C   = 1'b0;
        case (bus.fu_FS)
            4'b0010: begin
                fu_sum   = {1'b0, bus.fu_A} + {1'b0, bus.fu_B};
                bus.fu_F = fu_sum[31:0];
                bus.fu_C = fu_sum[32];
            end
            4'b1110: bus.fu_F = bus.fu_B << bus.fu_SH;
            4'b1101: bus.fu_F = bus.fu_B >> bus.fu_SH;
            default: bus.fu_F = bus.fu_A ^ bus.fu_B;
        endcase
        bus.fu_Z = (bus.fu_F == 32'd0);
    end

    // Expected per-cycle function-unit request {FS, SH, A, B}.
    logic [72:0] exp_ops [0:127];

    task automatic build_ops(input logic [31:0] a, input logic [31:0] b, output int n);
        int          len;
        logic [31:0] p;
        logic [31:0] m;
        len = 0;
        for (int k = 0; k < 32; k++) if (b[k]) len = k + 1;
        n = 0;
        p = 32'd0;
        for (int k = 0; k < len; k++) begin
            m = a << k;
            if (b[k]) begin
                exp_ops[n] = {4'b0010, 5'd0, p, m};
                p = p + m;
                n++;
            end
            exp_ops[n] = {4'b1110, 5'd1, 32'd0, m};
            n++;
            exp_ops[n] = {4'b1101, 5'd1, 32'd0, b >> k};
            n++;
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit noisy);
        int          n;
        logic [63:0] prod;
        logic        exp_ovf;
        logic [72:0] got;
        build_ops(a, b, n);
        prod    = 64'(a) * 64'(b);
        exp_ovf = (prod[63:32] != 32'd0);

        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy a=%h b=%h got=%b exp=0", a, b, bus.busy);
        end
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;

        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c <= n) begin
                got = {bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B};
                checks++;
                if (got !== exp_ops[c-1]) begin
                    errors++;
                    $display("FAIL fu_op a=%h b=%h cycle=%0d got=%h exp=%h", a, b, c, got, exp_ops[c-1]);
                end
                checks++;
                if ({bus.busy, bus.done} !== 2'b10) begin
                    errors++;
                    $display("FAIL busy_done a=%h b=%h cycle=%0d got=%b exp=10", a, b, c, {bus.busy, bus.done});
                end
            end else begin
                checks++;
                if ({bus.busy, bus.done} !== 2'b11) begin
                    errors++;
                    $display("FAIL done_cycle a=%h b=%h cycle=%0d got=%b exp=11", a, b, c, {bus.busy, bus.done});
                end
                checks++;
                if (bus.result !== prod[31:0]) begin
                    errors++;
                    $display("FAIL result a=%h b=%h got=%h exp=%h", a, b, bus.result, prod[31:0]);
                end
                checks++;
                if (bus.ovf !== exp_ovf) begin
                    errors++;
                    $display("FAIL ovf a=%h b=%h got=%b exp=%b", a, b, bus.ovf, exp_ovf);
                end
                checks++;
                if ({bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B} !== 73'd0) begin
                    errors++;
                    $display("FAIL fu_done_zero a=%h b=%h got=%h exp=0", a, b,
                             {bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B});
                end
            end
            bus.pipe_FS = 4'($urandom);
            bus.pipe_SH = 5'($urandom);
            bus.pipe_A  = $urandom;
            bus.pipe_B  = $urandom;
            if (noisy && c <= n) begin
                bus.start = 1'b1;
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.pipe_FS = 4'b0110;
        bus.pipe_SH = 5'd3;
        bus.pipe_A  = 32'h1111_2222;
        bus.pipe_B  = 32'h3333_4444;
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b/%h exp=000/0", bus.busy, bus.done, bus.ovf, bus.result);
        end
        checks++;
        if ({bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B} !== {4'b0110, 5'd3, 32'h1111_2222, 32'h3333_4444}) begin
            errors++;
            $display("FAIL reset_passthrough got=%h", {bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.pipe_FS = 4'b1010;
                bus.pipe_SH = 5'd0;
                bus.pipe_A  = 32'h0000_FFFF;
                bus.pipe_B  = 32'h0FFF_FFFF;
            end else begin
                bus.pipe_FS = 4'($urandom);
                bus.pipe_SH = 5'($urandom);
                bus.pipe_A  = $urandom;
                bus.pipe_B  = $urandom;
            end
            #1;
            checks++;
            if ({bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B} !== {bus.pipe_FS, bus.pipe_SH, bus.pipe_A, bus.pipe_B}) begin
                errors++;
                $display("FAIL passthrough i=%0d got=%h exp=%h", i, {bus.fu_FS, bus.fu_SH, bus.fu_A, bus.fu_B},
                         {bus.pipe_FS, bus.pipe_SH, bus.pipe_A, bus.pipe_B});
            end
        end
    endtask

    task automatic test_directed();
        run_mul(32'd6, 32'd7, 1'b0);
        run_mul(32'h1234_5678, 32'd0, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_mul(32'h0001_0000, 32'h0001_0000, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
        run_mul($urandom, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_mul($urandom, $urandom >> 20, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++;
                $display("FAIL extra_done i=%0d got=%b exp=00", i, {bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_reset_mid();
        run_mul(32'd6, 32'd7, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got=%b%b%b/%h exp=000/0", bus.busy, bus.done, bus.ovf, bus.result);
        end
        checks++;
        if (bus.fu_FS !== bus.pipe_FS || bus.fu_B !== bus.pipe_B) begin
            errors++;
            $display("FAIL mid_reset_passthrough got=%h/%h exp=%h/%h", bus.fu_FS, bus.fu_B, bus.pipe_FS, bus.pipe_B);
        end
        @(negedge clk);
        rst = 1'b0;
        run_mul(32'd3, 32'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            run_mul($urandom >> $urandom_range(0, 31), $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_passthrough();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
